// File: rtl/frontend_ctrl.sv
// Qu front-end sequencing controller: boot hold, redirect arbitration, flush/refill, throttling.
// Perf counters (redirect_cnt, stall_cnt) are built only when QU_FE_PERF_CNT_EN is defined.
`ifndef QU_PC_WIDTH
`define QU_PC_WIDTH 32
`endif

module frontend_ctrl #(
    parameter int unsigned PC_WIDTH     = `QU_PC_WIDTH,
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
`ifdef QU_FE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_pc,
    input  logic                br_req,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic                jmp_req,
    input  logic [PC_WIDTH-1:0] jmp_pc,
    input  logic                halt_req,
    input  logic                map_full,
    input  logic                res_st_full,
    input  logic                rob_full,
    output logic                if_en,
    output logic                id_en,
    output logic                exception,
    output logic                branch,
    output logic                jump,
    output logic [PC_WIDTH-1:0] pc_override,
    output logic                stall,
    output logic                if_stall,
    output logic                id_stall,
    output logic                mp_stall,
    output logic                rn_stall,
    output logic                flush,
    output logic                busy
`ifdef QU_FE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] redirect_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    localparam logic [2:0] StBoot     = 3'd0;
    localparam logic [2:0] StRun      = 3'd1;
    localparam logic [2:0] StRedirect = 3'd2;
    localparam logic [2:0] StFlush    = 3'd3;
    localparam logic [2:0] StRefill   = 3'd4;

    localparam int unsigned CntMax = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] BootInit  = CntW'(BOOT_CYCLES - 1);
    localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                if_en_q, if_en_d, id_en_q, id_en_d;
    logic                exc_q, exc_d, br_q, br_d, jmp_q, jmp_d;
    logic                stall_q, stall_d, flush_q, flush_d, busy_q, busy_d;
    logic                if_stall_q, if_stall_d, id_stall_q, id_stall_d;
    logic                mp_stall_q, mp_stall_d, rn_stall_q, rn_stall_d;
    logic                req, rn_press;

    // Any request, in any state, restarts the redirect sequence.
    always_comb begin
        req     = exc_req | br_req | jmp_req;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StBoot: begin
                if (cnt_q == '0) state_d = StRun;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StRedirect: begin
                state_d = StFlush;
                cnt_d   = FlushInit;
            end
            StFlush: begin
                if (cnt_q == '0) state_d = StRefill;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StRefill: state_d = StRun;
            StRun:    state_d = StRun;
            default:  state_d = StBoot;
        endcase
        if (req) state_d = StRedirect;
    end

    // Outputs are decoded from the next state so they appear registered with it.
    always_comb begin
        rn_press   = res_st_full | rob_full;
        if_en_d    = 1'b0;
        id_en_d    = 1'b0;
        exc_d      = 1'b0;
        br_d       = 1'b0;
        jmp_d      = 1'b0;
        pc_d       = pc_q;
        stall_d    = 1'b1;
        flush_d    = 1'b1;
        busy_d     = 1'b1;
        if_stall_d = 1'b1;
        id_stall_d = 1'b1;
        mp_stall_d = 1'b1;
        rn_stall_d = 1'b1;
        case (state_d)
            StRun: begin
                if_en_d    = 1'b1;
                id_en_d    = 1'b1;
                stall_d    = halt_req;
                flush_d    = 1'b0;
                busy_d     = 1'b0;
                if_stall_d = halt_req;
                id_stall_d = 1'b0;
                rn_stall_d = rn_press;
                mp_stall_d = map_full | rn_press;
            end
            StRedirect: begin
                exc_d = exc_req;
                br_d  = br_req & ~exc_req;
                jmp_d = jmp_req & ~exc_req & ~br_req;
                if (exc_req)     pc_d = exc_pc;
                else if (br_req) pc_d = br_pc;
                else             pc_d = jmp_pc;
            end
            StRefill: begin
                if_en_d    = 1'b1;
                stall_d    = 1'b0;
                flush_d    = 1'b0;
                if_stall_d = halt_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            cnt_q      <= BootInit;
            pc_q       <= '0;
            if_en_q    <= 1'b0;
            id_en_q    <= 1'b0;
            exc_q      <= 1'b0;
            br_q       <= 1'b0;
            jmp_q      <= 1'b0;
            stall_q    <= 1'b1;
            flush_q    <= 1'b1;
            busy_q     <= 1'b1;
            if_stall_q <= 1'b1;
            id_stall_q <= 1'b1;
            mp_stall_q <= 1'b1;
            rn_stall_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            if_en_q    <= if_en_d;
            id_en_q    <= id_en_d;
            exc_q      <= exc_d;
            br_q       <= br_d;
            jmp_q      <= jmp_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            busy_q     <= busy_d;
            if_stall_q <= if_stall_d;
            id_stall_q <= id_stall_d;
            mp_stall_q <= mp_stall_d;
            rn_stall_q <= rn_stall_d;
        end
    end

    assign if_en       = if_en_q;
    assign id_en       = id_en_q;
    assign exception   = exc_q;
    assign branch      = br_q;
    assign jump        = jmp_q;
    assign pc_override = pc_q;
    assign stall       = stall_q;
    assign flush       = flush_q;
    assign busy        = busy_q;
    assign if_stall    = if_stall_q;
    assign id_stall    = id_stall_q;
    assign mp_stall    = mp_stall_q;
    assign rn_stall    = rn_stall_q;

`ifdef QU_FE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d, stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (state_q == StRedirect && redirect_cnt_q != '1) redirect_cnt_d = redirect_cnt_q + 1'b1;
        if (stall_q && state_q != StBoot && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule
